// File: rtl/jtt_pkg.sv
// Shared types and default sizing for the multi-bank jump target table.
// Default geometry: 4 banks of 32 entries with 12-bit targets.
package jtt_pkg;

    localparam int unsigned JTT_ADDR_W    = 12;
    localparam int unsigned JTT_IDX_W     = 5;
    localparam int unsigned JTT_NUM_BANKS = 4;

    // Bank select width, never narrower than one bit.
    function automatic int unsigned jtt_bank_w(input int unsigned num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

    localparam int unsigned BANK_W  = jtt_bank_w(JTT_NUM_BANKS);
    localparam int unsigned ENTRIES = JTT_NUM_BANKS << JTT_IDX_W;

    typedef enum logic [0:0] {
        INIT,
        READY
    } jtt_state_t;

    typedef struct packed {
        logic                  vld;
        logic [JTT_ADDR_W-1:0] tgt;
    } jtt_entry_t;

endpackage

// File: rtl/jump_target_table_if.sv
// Lookup and loader-write bus of the jump target table.
// The master side is driven by the branch unit and program loader.
interface jump_target_table_if
    import jtt_pkg::*;
#(
    parameter int unsigned ADDR_W = JTT_ADDR_W,
    parameter int unsigned IDX_W  = JTT_IDX_W,
    parameter int unsigned BANK_W = jtt_pkg::BANK_W
);

    logic [BANK_W-1:0] bank_sel;
    logic              rd_en;
    logic [IDX_W-1:0]  rd_idx;
    logic              rel_mode;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] jump;
    logic              jump_valid;
    logic              rd_err;
    logic              wrap;
    logic              wr_en;
    logic [BANK_W-1:0] wr_bank;
    logic [IDX_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_data;
    logic              wr_ready;
    logic              init_done;

    modport master (
        output bank_sel, rd_en, rd_idx, rel_mode, pc,
        output wr_en, wr_bank, wr_idx, wr_data,
        input  jump, jump_valid, rd_err, wrap, wr_ready, init_done
    );

    modport slave (
        input  bank_sel, rd_en, rd_idx, rel_mode, pc,
        input  wr_en, wr_bank, wr_idx, wr_data,
        output jump, jump_valid, rd_err, wrap, wr_ready, init_done
    );

endinterface

// File: rtl/jtt_rel_adder.sv
// PC-relative target adder; carry_o flags a wrap past the top of the address space.
module jtt_rel_adder #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] ofs_i,
    output logic [ADDR_W-1:0] sum_o,
    output logic              carry_o
);

    always_comb begin
        {carry_o, sum_o} = {1'b0, pc_i} + {1'b0, ofs_i};
    end

endmodule

// File: rtl/jump_target_table.sv
// Multi-bank runtime-writable branch target store with a post-reset valid-bit sweep
// and a registered one-cycle lookup (absolute or PC-relative).
module jump_target_table
    import jtt_pkg::*;
#(
    parameter int unsigned ADDR_W    = JTT_ADDR_W,
    parameter int unsigned IDX_W     = JTT_IDX_W,
    parameter int unsigned NUM_BANKS = JTT_NUM_BANKS
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    jump_target_table_if.slave        bus
);

    localparam int unsigned BankW   = jtt_bank_w(NUM_BANKS);
    localparam int unsigned Entries = NUM_BANKS << IDX_W;
    localparam int unsigned LinW    = BankW + IDX_W;

    localparam logic [LinW-1:0]  LastCnt   = LinW'(Entries - 1);
    localparam logic [BankW:0]   NumBanksL = (BankW + 1)'(NUM_BANKS);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] tgt;
    } entry_t;

    jtt_state_t        state_q, state_d;
    logic [LinW-1:0]   cnt_q, cnt_d;

    logic [Entries-1:0] vld_q;
    logic [ADDR_W-1:0]  tgt_mem [Entries];

    logic [ADDR_W-1:0] jump_q, jump_d;
    logic              jump_valid_q, jump_valid_d;
    logic              rd_err_q, rd_err_d;
    logic              wrap_q, wrap_d;

    logic              ready;
    logic              wr_fire;
    logic [LinW-1:0]   wr_addr;
    logic [LinW-1:0]   rd_addr;
    logic              rd_bank_ok;
    entry_t            rd_entry;
    logic [ADDR_W-1:0] rel_sum;
    logic              rel_carry;

    // ---------------- Init sweep FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign ready = (state_q == READY);

    // ---------------- Storage ----------------
    assign wr_addr    = {bus.wr_bank, bus.wr_idx};
    assign rd_addr    = {bus.bank_sel, bus.rd_idx};
    assign wr_fire    = bus.wr_en && ready && ({1'b0, bus.wr_bank} < NumBanksL);
    assign rd_bank_ok = ({1'b0, bus.bank_sel} < NumBanksL);

    // Valid bits are cleared only by the sweep, so no reset branch here.
    always_ff @(posedge clk_i) begin
        if (!ready) begin
            vld_q[cnt_q] <= 1'b0;
        end else if (wr_fire) begin
            vld_q[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            tgt_mem[wr_addr] <= bus.wr_data;
        end
    end

    // ---------------- Lookup ----------------
    always_comb begin
        rd_entry.vld = 1'b0;
        rd_entry.tgt = '0;
        if (rd_bank_ok) begin
            rd_entry.vld = vld_q[rd_addr];
            rd_entry.tgt = tgt_mem[rd_addr];
            // Write-first bypass for a same-cycle write to the looked-up entry.
            if (wr_fire && (wr_addr == rd_addr)) begin
                rd_entry.vld = 1'b1;
                rd_entry.tgt = bus.wr_data;
            end
        end
    end

    jtt_rel_adder #(
        .ADDR_W (ADDR_W)
    ) u_rel_adder (
        .pc_i    (bus.pc),
        .ofs_i   (rd_entry.tgt),
        .sum_o   (rel_sum),
        .carry_o (rel_carry)
    );

    always_comb begin
        jump_d       = jump_q;
        jump_valid_d = 1'b0;
        rd_err_d     = 1'b0;
        wrap_d       = 1'b0;
        if (bus.rd_en) begin
            if (!ready || !rd_entry.vld) begin
                rd_err_d = 1'b1;
                jump_d   = '0;
            end else begin
                jump_valid_d = 1'b1;
                if (bus.rel_mode) begin
                    jump_d = rel_sum;
                    wrap_d = rel_carry;
                end else begin
                    jump_d = rd_entry.tgt;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            jump_q       <= '0;
            jump_valid_q <= 1'b0;
            rd_err_q     <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            jump_q       <= jump_d;
            jump_valid_q <= jump_valid_d;
            rd_err_q     <= rd_err_d;
            wrap_q       <= wrap_d;
        end
    end

    assign bus.jump       = jump_q;
    assign bus.jump_valid = jump_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.wrap       = wrap_q;
    assign bus.wr_ready   = ready;
    assign bus.init_done  = ready;

endmodule

// File: tb/tb_jump_target_table.sv
// Directed bench for jump_target_table: init sweep timing, lookups, writes and reset restart.
module tb_jump_target_table;

    localparam int unsigned AW = 12;
    localparam int unsigned IW = 5;
    localparam int unsigned NB = 4;
    localparam int unsigned BW = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    jump_target_table_if #(.ADDR_W(AW), .IDX_W(IW), .BANK_W(BW)) bus ();

    jump_target_table #(
        .ADDR_W    (AW),
        .IDX_W     (IW),
        .NUM_BANKS (NB)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int b, input int i, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_bank = BW'(b);
        bus.wr_idx  = IW'(i);
        bus.wr_data = AW'(d);
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input int b, input int i, input logic rel, input int pc);
        bus.rd_en    = 1'b1;
        bus.bank_sel = BW'(b);
        bus.rd_idx   = IW'(i);
        bus.rel_mode = rel;
        bus.pc       = AW'(pc);
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int cyc;
        cyc = 0;
        while (!bus.init_done && cyc < 400) begin
            tick();
            cyc++;
        end
        check_eq(tag, cyc, 128);
    endtask

    initial begin
        int cyc;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.bank_sel = '0; bus.rd_en = 1'b0; bus.rd_idx = '0; bus.rel_mode = 1'b0;
        bus.pc = '0; bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_idx = '0; bus.wr_data = '0;
        tick(); tick();

        check_eq("rst_jump", bus.jump, 0);
        check_eq("rst_valid", bus.jump_valid, 0);
        check_eq("rst_err", bus.rd_err, 0);
        check_eq("rst_wrap", bus.wrap, 0);
        check_eq("rst_wr_ready", bus.wr_ready, 0);
        check_eq("rst_init_done", bus.init_done, 0);

        // First sweep: read during INIT, and a write that must be dropped.
        rst_n = 1'b1;
        bus.rd_en = 1'b1; bus.bank_sel = 0; bus.rd_idx = 0;
        cyc = 0;
        while (!bus.init_done && cyc < 400) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                check_eq("init_rd_err", bus.rd_err, 1);
                check_eq("init_rd_valid", bus.jump_valid, 0);
                check_eq("init_rd_jump", bus.jump, 0);
                bus.rd_en = 1'b0;
            end
            if (cyc == 119) begin
                check_eq("init_wr_ready", bus.wr_ready, 0);
                bus.wr_en = 1'b1; bus.wr_bank = 0; bus.wr_idx = 7; bus.wr_data = 12'h123;
            end
            if (cyc == 120) bus.wr_en = 1'b0;
        end
        check_eq("init_cycles", cyc, 128);
        check_eq("ready_wr_ready", bus.wr_ready, 1);

        do_read(0, 7, 1'b0, 0);
        check_eq("dropped_wr_err", bus.rd_err, 1);
        check_eq("dropped_wr_valid", bus.jump_valid, 0);

        // Absolute lookup and bank isolation.
        do_write(1, 9, 32);
        do_read(1, 9, 1'b0, 12'h7AB);
        check_eq("abs_jump", bus.jump, 32);
        check_eq("abs_valid", bus.jump_valid, 1);
        check_eq("abs_err", bus.rd_err, 0);
        tick();
        check_eq("idle_valid", bus.jump_valid, 0);
        check_eq("idle_hold_jump", bus.jump, 32);
        do_read(0, 9, 1'b0, 0);
        check_eq("other_bank_err", bus.rd_err, 1);
        check_eq("other_bank_jump", bus.jump, 0);

        // Relative lookups with and without wrap.
        do_write(2, 3, 12'hFF0);
        do_read(2, 3, 1'b1, 12'h020);
        check_eq("rel_wrap_jump", bus.jump, 12'h010);
        check_eq("rel_wrap_flag", bus.wrap, 1);
        do_read(2, 3, 1'b1, 12'h005);
        check_eq("rel_nowrap_jump", bus.jump, 12'hFF5);
        check_eq("rel_nowrap_flag", bus.wrap, 0);
        do_read(2, 3, 1'b0, 12'h020);
        check_eq("abs_ignores_pc", bus.jump, 12'hFF0);

        // Same-cycle write and read of one entry.
        bus.wr_en = 1'b1; bus.wr_bank = 0; bus.wr_idx = 4; bus.wr_data = 12'h0A4;
        do_read(0, 4, 1'b0, 0);
        bus.wr_en = 1'b0;
        check_eq("wr_first_jump", bus.jump, 12'h0A4);
        check_eq("wr_first_valid", bus.jump_valid, 1);

        // Last entry of the last bank.
        do_write(3, 31, 12'h7FF);
        do_read(3, 31, 1'b0, 0);
        check_eq("last_entry_jump", bus.jump, 12'h7FF);

        // Async reset clears outputs; mid-sweep reset restarts the sweep.
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_jump", bus.jump, 0);
        check_eq("async_rst_init_done", bus.init_done, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) tick();
        check_eq("mid_sweep_init_done", bus.init_done, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_init("restart_cycles");
        do_read(1, 9, 1'b0, 0);
        check_eq("post_rst_err_a", bus.rd_err, 1);
        do_read(2, 3, 1'b0, 0);
        check_eq("post_rst_err_b", bus.rd_err, 1);

        // A write in READY is accepted.
        do_write(0, 7, 12'h456);
        do_read(0, 7, 1'b0, 0);
        check_eq("ready_wr_jump", bus.jump, 12'h456);
        check_eq("ready_wr_valid", bus.jump_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jump_target_table.md
Name: jump_target_table

Overview:
- Parametrised successor to the fixed 32-entry jump lookup table: a multi-bank, runtime-writable branch-target store for the 9-bit processor.
- Each program gets its own bank, selected by the fetch unit.
- After reset, the block self-clears all entries, then accepts writes from the program loader and lookups from the branch unit.
- Lookups are registered, take one cycle, and support absolute targets or PC-relative targets with wrap detection.

Parameters:
- ADDR_W, 12, width of a jump target and of the PC.
- IDX_W, 5, index width; each bank holds 2**IDX_W entries.
- NUM_BANKS, 4, number of program banks; BANK_W = $clog2(NUM_BANKS), minimum 1.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  reset; asynchronous, active-low.
- Bank_sel  in  BANK_W  bank used for lookups.
- Rd_en  in  1  lookup request.
- Rd_idx  in  IDX_W  lookup index.
- Rel_mode  in  1  0 = absolute target, 1 = target is Pc + entry.
- Pc  in  ADDR_W  PC of the branch instruction; used only when Rel_mode = 1.
- Jump  out  ADDR_W  resolved target, registered.
- Jump_valid  out  1  Jump is valid this cycle.
- Rd_err  out  1  lookup hit an unwritten entry, or was issued during init.
- Wrap  out  1  relative add overflowed ADDR_W.
- Wr_en  in  1  write request; accepted only when Wr_ready = 1.
- Wr_bank  in  BANK_W  write bank.
- Wr_idx  in  IDX_W  write index.
- Wr_data  in  ADDR_W  target to store.
- Wr_ready  out  1  table accepts writes.
- Init_done  out  1  init sweep complete.

Behaviour:
Reset (Reset_n low, asynchronous):
- All outputs go to 0.
- FSM goes to INIT; sweep counter goes to 0.
- The storage array itself is not reset; only the per-entry valid bits are cleared, by the sweep.

State machine: INIT, READY.
- INIT:
  - Each cycle, clear the valid bit of entry {bank,idx} = counter, then increment the counter.
  - The sweep covers all NUM_BANKS * 2**IDX_W entries, so it lasts exactly NUM_BANKS * 2**IDX_W cycles after Reset_n rises.
  - When the counter reaches its final value, go to READY on the next edge.
  - Wr_ready = 0 and Init_done = 0 throughout INIT.
- READY:
  - Init_done = 1 and Wr_ready = 1.
  - No exit except reset.
- Reset asserted mid-sweep restarts INIT from counter 0.

Write:
- When Wr_en = 1 and Wr_ready = 1, on the clock edge store Wr_data at {Wr_bank, Wr_idx} and set that entry's valid bit.
- When Wr_en = 1 and Wr_ready = 0, drop the write silently; no state changes.

Read (latency 1):
- Rd_en sampled at edge t; Jump, Jump_valid, Rd_err and Wrap update at edge t+1.
- The result is held for one cycle only: Jump_valid deasserts the cycle after unless Rd_en stays asserted.
- In INIT: Jump_valid = 0, Rd_err = 1, Jump = 0.
- In READY with a valid entry E:
  - Rel_mode = 0: Jump = E, Wrap = 0.
  - Rel_mode = 1: Jump = (Pc + E) mod 2**ADDR_W; Wrap = carry out of bit ADDR_W-1.
  - Jump_valid = 1, Rd_err = 0.
- In READY with an invalid entry: Jump_valid = 0, Rd_err = 1, Jump = 0, Wrap = 0.
- Rd_en = 0: Jump_valid, Rd_err and Wrap = 0; Jump holds its last value.

Simultaneous events:
- A write and a read to the same {bank,idx} in the same cycle are write-first: the read returns Wr_data and valid = 1.
- Writes to different entries do not disturb reads.

Bank handling:
- Out-of-range Bank_sel or Wr_bank (values >= NUM_BANKS, possible when NUM_BANKS is not a power of 2) is handled as follows:
  - A read returns Rd_err = 1.
  - A write is dropped.
- Pc is ignored when Rel_mode = 0.

Decomposition:
- Package jtt_pkg holds:
  - typedef enum logic [0:0] {INIT, READY} jtt_state_t;
  - helper localparams ENTRIES = NUM_BANKS << IDX_W and BANK_W.
  - typedef struct packed {logic vld; logic [ADDR_W-1:0] tgt;} for an entry, as a parametrised-width helper or macro.
- One sub-module, jtt_rel_adder: a combinational ADDR_W adder with carry-out, producing the target and Wrap.
- Storage and FSM stay in the top module.

Test Plan:
- Release reset with defaults; count cycles -> Init_done rises exactly 128 cycles later; Rd_en during the sweep gives Rd_err = 1 and Jump_valid = 0.
- After init, write bank 1, idx 9, data 32; read Bank_sel = 1, Rd_idx = 9, Rel_mode = 0 -> next cycle Jump = 32, Jump_valid = 1; the same idx in bank 0 gives Rd_err = 1.
- Write bank 2, idx 3, data 0xFF0; read with Rel_mode = 1 and Pc = 0x020 -> Jump = 0x010, Wrap = 1; with Pc = 0x005 -> Jump = 0xFF5, Wrap = 0.
- Same-cycle write (bank 0, idx 4, data 0x0A4) and read of the same entry -> next cycle Jump = 0x0A4, Jump_valid = 1.
- Drop Reset_n at sweep count 50, release it -> Init_done after a further 128 cycles; entries written before the reset now read Rd_err = 1.
- Wr_en during INIT with data 0x123 -> after init, reading that entry gives Rd_err = 1 (write dropped); a write in READY is accepted.
